// File: rtl/tlk2711_mc_tx_cmd.sv
// rtl/tlk2711_mc_tx_cmd.sv - multi-channel TX DMA read command scheduler (round-robin, one command in flight)
// Optional watchdog on the in-flight command: define TLK2711_TX_CMD_TIMEOUT_EN.
module tlk2711_mc_tx_cmd #(
  parameter int ADDR_WIDTH     = 48,
  parameter int DLEN_WIDTH     = 16,
  parameter int CH_NUM         = 4,
  parameter int CH_WIDTH       = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_soft_rst,
  input  logic [CH_NUM-1:0]                i_tx_start,
  input  logic [CH_NUM*ADDR_WIDTH-1:0]     i_tx_base_addr,
  input  logic [CH_NUM*16-1:0]             i_tx_packet_body,
  input  logic [CH_NUM*16-1:0]             i_tx_packet_tail,
  input  logic [CH_NUM*16-1:0]             i_tx_body_num,
  output logic                             o_rd_cmd_req,
  output logic [DLEN_WIDTH+ADDR_WIDTH-1:0] o_rd_cmd_data,
  output logic [CH_WIDTH-1:0]              o_rd_cmd_ch,
  input  logic                             i_rd_cmd_ack,
  input  logic                             i_dma_rd_last,
  output logic [CH_NUM-1:0]                o_ch_busy,
  output logic [CH_NUM-1:0]                o_ch_done,
  output logic [CH_NUM-1:0]                o_start_err,
  output logic                             o_timeout_irq
);

  typedef enum logic [1:0] {IDLE, ARB, REQ, WAIT_LAST} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   ctx_addr     [CH_NUM];
  logic [DLEN_WIDTH-1:0]   ctx_body     [CH_NUM];
  logic [DLEN_WIDTH-1:0]   ctx_tail     [CH_NUM];
  logic [15:0]             ctx_body_rem [CH_NUM];
  logic [CH_NUM-1:0]       ctx_tail_en;
  logic [CH_WIDTH-1:0]     last_ch;
  logic [DLEN_WIDTH-1:0]   cmd_len;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [CH_WIDTH-1:0]     sel_ch;
  logic [CH_WIDTH-1:0]     rr_idx;
  logic                    sel_found;
  logic                    cur_final;

`ifdef TLK2711_TX_CMD_TIMEOUT_EN
  logic [31:0]             tmo_cnt;
`else
  assign o_timeout_irq = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

  assign o_rd_cmd_data = {cmd_len, cmd_addr};

  // The tail packet is the last one; otherwise the last body packet ends the job when no tail exists.
  assign cur_final = (ctx_body_rem[o_rd_cmd_ch] == 16'd0) ||
                     ((ctx_body_rem[o_rd_cmd_ch] == 16'd1) && !ctx_tail_en[o_rd_cmd_ch]);

  // Round-robin search starts one past the last served channel.
  always_comb begin
    sel_ch    = '0;
    sel_found = 1'b0;
    rr_idx    = '0;
    for (int i = 1; i <= CH_NUM; i++) begin
      rr_idx = CH_WIDTH'((int'(last_ch) + i) % CH_NUM);
      if (!sel_found && o_ch_busy[rr_idx]) begin
        sel_found = 1'b1;
        sel_ch    = rr_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_ch      <= CH_WIDTH'(CH_NUM - 1);
      o_rd_cmd_ch  <= '0;
      o_rd_cmd_req <= 1'b0;
      cmd_len      <= '0;
      cmd_addr     <= '0;
      o_ch_busy    <= '0;
      o_ch_done    <= '0;
      o_start_err  <= '0;
      ctx_tail_en  <= '0;
      for (int k = 0; k < CH_NUM; k++) begin
        ctx_addr[k]     <= '0;
        ctx_body[k]     <= '0;
        ctx_tail[k]     <= '0;
        ctx_body_rem[k] <= '0;
      end
`ifdef TLK2711_TX_CMD_TIMEOUT_EN
      tmo_cnt       <= '0;
      o_timeout_irq <= 1'b0;
`endif
    end else if (i_soft_rst) begin
      state        <= IDLE;
      last_ch      <= CH_WIDTH'(CH_NUM - 1);
      o_rd_cmd_ch  <= '0;
      o_rd_cmd_req <= 1'b0;
      cmd_len      <= '0;
      cmd_addr     <= '0;
      o_ch_busy    <= '0;
      o_ch_done    <= '0;
      o_start_err  <= '0;
      ctx_tail_en  <= '0;
      for (int k = 0; k < CH_NUM; k++) begin
        ctx_addr[k]     <= '0;
        ctx_body[k]     <= '0;
        ctx_tail[k]     <= '0;
        ctx_body_rem[k] <= '0;
      end
`ifdef TLK2711_TX_CMD_TIMEOUT_EN
      tmo_cnt       <= '0;
      o_timeout_irq <= 1'b0;
`endif
    end else begin
      o_ch_done   <= '0;
      o_start_err <= '0;

      // A channel finishing this cycle still reads busy here, so its start is rejected.
      for (int k = 0; k < CH_NUM; k++) begin
        if (i_tx_start[k]) begin
          if (o_ch_busy[k]) begin
            o_start_err[k] <= 1'b1;
          end else if ((i_tx_body_num[k*16 +: 16] == 16'd0) &&
                       (i_tx_packet_tail[k*16 +: 16] == 16'd0)) begin
            o_ch_done[k] <= 1'b1;
          end else begin
            ctx_addr[k]     <= i_tx_base_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            ctx_body[k]     <= DLEN_WIDTH'(i_tx_packet_body[k*16 +: 16]);
            ctx_tail[k]     <= DLEN_WIDTH'(i_tx_packet_tail[k*16 +: 16]);
            ctx_body_rem[k] <= i_tx_body_num[k*16 +: 16];
            ctx_tail_en[k]  <= (i_tx_packet_tail[k*16 +: 16] != 16'd0);
            o_ch_busy[k]    <= 1'b1;
          end
        end
      end

      case (state)
        IDLE: begin
          if (|o_ch_busy) state <= ARB;
        end
        ARB: begin
          if (sel_found) begin
            o_rd_cmd_ch  <= sel_ch;
            last_ch      <= sel_ch;
            cmd_addr     <= ctx_addr[sel_ch];
            cmd_len      <= (ctx_body_rem[sel_ch] != 16'd0) ? ctx_body[sel_ch] : ctx_tail[sel_ch];
            o_rd_cmd_req <= 1'b1;
            state        <= REQ;
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          if (i_rd_cmd_ack) begin
            o_rd_cmd_req <= 1'b0;
            state        <= WAIT_LAST;
          end
        end
        WAIT_LAST: begin
          if (i_dma_rd_last) begin
            ctx_addr[o_rd_cmd_ch] <= ctx_addr[o_rd_cmd_ch] + ADDR_WIDTH'(cmd_len);
            if (ctx_body_rem[o_rd_cmd_ch] != 16'd0)
              ctx_body_rem[o_rd_cmd_ch] <= ctx_body_rem[o_rd_cmd_ch] - 16'd1;
            else
              ctx_tail_en[o_rd_cmd_ch] <= 1'b0;
            if (cur_final) begin
              o_ch_busy[o_rd_cmd_ch] <= 1'b0;
              o_ch_done[o_rd_cmd_ch] <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

`ifdef TLK2711_TX_CMD_TIMEOUT_EN
      // Abort overrides whatever the command handshake did this cycle.
      o_timeout_irq <= 1'b0;
      if (state == REQ || state == WAIT_LAST) begin
        if (tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          tmo_cnt                <= '0;
          o_timeout_irq          <= 1'b1;
          o_ch_busy[o_rd_cmd_ch] <= 1'b0;
          o_ch_done[o_rd_cmd_ch] <= 1'b0;
          o_rd_cmd_req           <= 1'b0;
          state                  <= IDLE;
        end else begin
          tmo_cnt <= tmo_cnt + 32'd1;
        end
      end else begin
        tmo_cnt <= '0;
      end
`endif
    end
  end

endmodule
